period_meter: RTL and testbench
===============================

// Module: period_meter
// PURPOSE
//  Measures the period of a slow external square wave (SIG_IN) in CLK cycles; the inverse of the
//  4 MHz clock divider. Used to check divided/external clocks (e.g. 100 Hz tick) and feed display.
//  Reports the latest period, a one-cycle VALID strobe, a LOCK flag (stable period) and TIMEOUT.
// PARAMETERS
//  CNT_W    19        width of cycle counter and PERIOD output
//  TMO_CO   19'h61A80 timeout in CLK cycles (400000 = 0.1 s @ 4 MHz, i.e. below 10 Hz)
//  TOL      4         max |PERIOD_new - PERIOD_prev| in cycles still counted as stable
// PORTS
//  CLK      in   1      4 MHz system clock, all logic on posedge
//  RST_N    in   1      reset, synchronous, active-low
//  EN       in   1      measure enable; low forces IDLE
//  SIG_IN   in   1      asynchronous input signal to measure
//  PERIOD   out  CNT_W  last measured period, rising edge to rising edge, in CLK cycles
//  VALID    out  1      one-cycle strobe: PERIOD updated this cycle
//  LOCK     out  1      high while the last two periods differ by <= TOL
//  TIMEOUT  out  1      sticky: no rising edge within TMO_CO cycles; cleared by next VALID
// BEHAVIOUR
//  Reset (RST_N low at posedge CLK): PERIOD=0, VALID=0, LOCK=0, TIMEOUT=0, CNT=0, PREV=0,
//   state=IDLE, sync chain s1/s2/s3 = 1 (input held high after reset gives no false edge).
//  Sync: s1<=SIG_IN, s2<=s1, s3<=s2; RISE = s2 & ~s3. SIG_IN rise -> RISE 2 cycles later (visible 3rd).
//  FSM: IDLE  - CNT held 0; on RISE & EN -> MEAS, CNT<=0, no VALID (first edge only arms).
//       MEAS  - CNT<=CNT+1 each cycle; on RISE: PERIOD<=CNT+1, VALID<=1, PREV<=CNT+1, CNT<=0.
//               edges exactly N cycles apart give PERIOD=N; VALID rises 1 cycle after RISE.
//               on CNT==TMO_CO-1 without RISE: TIMEOUT<=1, LOCK<=0, -> IDLE, PERIOD holds.
//       EN low in any state -> IDLE next cycle, CNT<=0, LOCK<=0; PERIOD/TIMEOUT hold.
//  LOCK: evaluated on each VALID update, diff = |(CNT+1) - PREV| computed CNT_W+1 bits unsigned;
//   LOCK<=(diff<=TOL) && PREV!=0 (PREV=0 after reset/IDLE entry: first period never locks).
//   Entering IDLE also clears PREV to 0.
//  TIMEOUT cleared in the same cycle VALID is asserted; set/clear never simultaneous.
//  Simultaneous RISE and CNT==TMO_CO-1: RISE wins (valid period TMO_CO, no timeout).
//  CNT never wraps: max value TMO_CO-1 < 2**CNT_W; TMO_CO must fit CNT_W (elaboration check).
//  VALID high exactly one cycle; back-to-back VALID impossible (min period 2 after sync).
//  Reset mid-measurement: all outputs to reset values next posedge, partial count discarded.
// STRUCTURE
//  Shared package/include mpcd_defs: CLK_HZ=4000000, CNT_W=19, FSM encodings
//   ST_IDLE=1'b0, ST_MEAS=1'b1 as localparams.
//  Sub-module sync_edge (2-FF synchronizer + s3 delay + RISE detect, reset value 1).
//  Top holds FSM, counter, PERIOD/PREV registers, abs-diff compare, flags. ~150-200 lines.
// TESTING
//  1 SIG_IN toggled every 20001 CLK (100 Hz divider output), EN=1 -> 1st edge no VALID;
//    each later rise VALID, PERIOD=40002 (0x9C42); LOCK=1 from 2nd VALID onward.
//  2 Period 1000 then one period 1003 then 1010 -> LOCK stays 1 at 1003 (diff 3<=4),
//    drops 0 at 1010 (diff 7), rises again at next 1010.
//  3 SIG_IN stops after lock -> TIMEOUT=1 exactly 400000 cycles after last RISE, LOCK=0,
//    PERIOD holds 40002; restart: 1st edge no VALID, 2nd edge VALID, TIMEOUT=0 same cycle.
//  4 RISE lands on CNT==TMO_CO-1 -> VALID, PERIOD=400000 (0x61A80), TIMEOUT stays 0.
//  5 SIG_IN high through reset release -> no VALID, no arming until a low->high transition.
//  6 RST_N low 1 cycle mid-MEAS (CNT~20000) and EN low 1 cycle -> reset values / IDLE,
//    PREV cleared, next two edges give VALID on 2nd only with LOCK=0.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared constants and FSM encoding for the period meter.
// Imported by the top and the edge-detect sub-module.
package period_meter_pkg;

   localparam int unsigned CLK_HZ = 4000000;
   localparam int unsigned CNT_W  = 19;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MEAS = 1'b1
   } state_e;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Two-flop synchronizer plus one delay stage and rising-edge detect.
// Flops reset high so a signal held high through reset gives no edge.
module period_meter_sync_edge
   import period_meter_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_i,
   output logic rise_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= sig_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures rising-edge to rising-edge period of a slow input in clock
// cycles, with valid strobe, stability lock and sticky timeout flag.
module period_meter #(
   parameter int unsigned CNT_W  = period_meter_pkg::CNT_W,
   parameter int unsigned TMO_CO = 400000,
   parameter int unsigned TOL    = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             SIG_IN,
   output logic [CNT_W-1:0] PERIOD,
   output logic             VALID,
   output logic             LOCK,
   output logic             TIMEOUT
);
   import period_meter_pkg::*;

   if (TMO_CO < 2 || 64'(TMO_CO) >= (64'd1 << CNT_W)) begin : g_bad_tmo
      $error("TMO_CO does not fit the cycle counter");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CO - 1);
   localparam logic [CNT_W:0]   TOL_X    = (CNT_W + 1)'(TOL);

   logic             rise;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] prev_q, prev_d;
   logic             valid_q, valid_d;
   logic             lock_q, lock_d;
   logic             tmo_q, tmo_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W:0]   ext_new, ext_prev, diff;

   period_meter_sync_edge u_sync (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .sig_i  (SIG_IN),
      .rise_o (rise)
   );

   assign cnt_inc  = cnt_q + CNT_W'(1);
   assign ext_new  = {1'b0, cnt_inc};
   assign ext_prev = {1'b0, prev_q};
   assign diff     = (ext_new >= ext_prev) ? ext_new - ext_prev
                                           : ext_prev - ext_new;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      prev_d   = prev_q;
      valid_d  = 1'b0;
      lock_d   = lock_q;
      tmo_d    = tmo_q;
      if (!EN) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         prev_d  = '0;
         lock_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (rise) begin
                  state_d = ST_MEAS;
               end
            end
            ST_MEAS: begin
               cnt_d = cnt_inc;
               // An edge on the last count still yields a period.
               if (rise) begin
                  period_d = cnt_inc;
                  prev_d   = cnt_inc;
                  valid_d  = 1'b1;
                  tmo_d    = 1'b0;
                  cnt_d    = '0;
                  lock_d   = (diff <= TOL_X) && (prev_q != '0);
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  prev_d  = '0;
                  tmo_d   = 1'b1;
                  lock_d  = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         prev_q   <= '0;
         valid_q  <= 1'b0;
         lock_q   <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         prev_q   <= prev_d;
         valid_q  <= valid_d;
         lock_q   <= lock_d;
         tmo_q    <= tmo_d;
      end
   end

   assign PERIOD  = period_q;
   assign VALID   = valid_q;
   assign LOCK    = lock_q;
   assign TIMEOUT = tmo_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with a shortened timeout so the
// timeout and boundary cases fit a short run.
`timescale 1ns/1ps
module tb_period_meter;

   localparam int unsigned TMO = 6000;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        EN;
   logic        SIG_IN;
   logic [18:0] PERIOD;
   logic        VALID;
   logic        LOCK;
   logic        TIMEOUT;

   int n_chk  = 0;
   int n_fail = 0;
   int nv;

   always #5 CLK = ~CLK;

   period_meter #(
      .CNT_W  (19),
      .TMO_CO (TMO),
      .TOL    (4)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .EN      (EN),
      .SIG_IN  (SIG_IN),
      .PERIOD  (PERIOD),
      .VALID   (VALID),
      .LOCK    (LOCK),
      .TIMEOUT (TIMEOUT)
   );

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs,
                       input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs,
                       input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Raise SIG_IN and step to the cycle where VALID would show.
   task automatic rise3();
      SIG_IN = 1'b1;
      cyc(3);
   endtask

   // Finish a period of n cycles started by rise3.
   task automatic fin(input int n);
      cyc(1);
      chk1("valid_one_cycle", VALID, 1'b0);
      cyc(n / 2 - 4);
      SIG_IN = 1'b0;
      cyc(n - n / 2);
   endtask

   task automatic got(input int p, input logic l);
      chk1("valid", VALID, 1'b1);
      chki("period", int'(PERIOD), p);
      chk1("lock", LOCK, l);
      chk1("timeout_clr", TIMEOUT, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed no end expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST_N  = 1'b0;
      EN     = 1'b1;
      SIG_IN = 1'b1;
      cyc(3);
      chki("rst_period", int'(PERIOD), 0);
      chk1("rst_valid", VALID, 1'b0);
      chk1("rst_lock", LOCK, 1'b0);
      chk1("rst_timeout", TIMEOUT, 1'b0);

      // Input high through reset release: no edge, no arming.
      RST_N = 1'b1;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (VALID) nv++;
      end
      chki("high_thru_rst", nv, 0);
      SIG_IN = 1'b0;
      cyc(10);
      rise3();
      chk1("arm_no_valid", VALID, 1'b0);

      // Steady 2002-cycle period.
      fin(2002);
      rise3();
      got(2002, 1'b0);
      fin(2002);
      rise3();
      got(2002, 1'b1);
      fin(2002);
      rise3();
      got(2002, 1'b1);

      // Input stops: timeout exactly TMO cycles after last edge.
      SIG_IN = 1'b0;
      cyc(TMO - 1);
      chk1("tmo_early", TIMEOUT, 1'b0);
      cyc(1);
      chk1("tmo_set", TIMEOUT, 1'b1);
      chk1("tmo_lock", LOCK, 1'b0);
      chki("tmo_period", int'(PERIOD), 2002);
      cyc(5);
      rise3();
      chk1("rearm_no_valid", VALID, 1'b0);
      chk1("tmo_sticky", TIMEOUT, 1'b1);
      fin(1000);
      rise3();
      got(1000, 1'b0);

      // Tolerance window.
      fin(1000);
      rise3();
      got(1000, 1'b1);
      fin(1003);
      rise3();
      got(1003, 1'b1);
      fin(1010);
      rise3();
      got(1010, 1'b0);
      fin(1010);
      rise3();
      got(1010, 1'b1);

      // Edge on the last count wins over timeout.
      fin(TMO);
      rise3();
      got(TMO, 1'b0);
      // One cycle longer times out and only re-arms.
      fin(TMO + 1);
      rise3();
      chk1("late_no_valid", VALID, 1'b0);
      chk1("late_tmo", TIMEOUT, 1'b1);
      chki("late_period", int'(PERIOD), TMO);

      // Reset in the middle of a measurement.
      fin(2002);
      rise3();
      got(2002, 1'b0);
      fin(2002);
      rise3();
      got(2002, 1'b1);
      cyc(1);
      SIG_IN = 1'b0;
      cyc(1000);
      RST_N = 1'b0;
      cyc(1);
      chki("mid_rst_period", int'(PERIOD), 0);
      chk1("mid_rst_lock", LOCK, 1'b0);
      chk1("mid_rst_valid", VALID, 1'b0);
      chk1("mid_rst_timeout", TIMEOUT, 1'b0);
      RST_N = 1'b1;
      cyc(20);
      rise3();
      chk1("post_rst_arm", VALID, 1'b0);
      fin(2002);
      rise3();
      got(2002, 1'b0);
      fin(2002);
      rise3();
      got(2002, 1'b1);

      // One-cycle enable drop.
      cyc(1);
      SIG_IN = 1'b0;
      cyc(500);
      EN = 1'b0;
      cyc(1);
      chk1("en_low_lock", LOCK, 1'b0);
      chki("en_low_period", int'(PERIOD), 2002);
      EN = 1'b1;
      cyc(20);
      rise3();
      chk1("post_en_arm", VALID, 1'b0);
      fin(2002);
      rise3();
      got(2002, 1'b0);
      cyc(1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
